// File: rtl/alu_acc_seq.sv
// ---------------------------------------------------------------------------
// alu_acc_seq
//
// Accumulator sequencer placed directly in front of the registered `alu`
// block. It accepts one instruction at a time over a valid/ready handshake,
// presents opcode/operand/accumulator to the ALU, captures the registered ALU
// result one cycle later, optionally writes it back into the 8-bit
// accumulator, and returns the result over a second valid/ready handshake.
// Load instructions bypass the ALU and complete in a single cycle.
//
// Parameters:
//   WIDTH  datapath width (must match the ALU, only 8 is supported)
//   OPW    opcode width
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   instr_valid  instruction present
//   instr_ready  sequencer can accept an instruction (registered)
//   instr_op     ALU opcode
//   instr_data   ALU operand or load value
//   instr_load   1 = load instr_data into the accumulator (no ALU)
//   instr_wb     1 = write the ALU result back into the accumulator
//   alu_opcode   -> ALU opcode
//   alu_data     -> ALU data
//   alu_accum    -> ALU accum
//   alu_result   <- ALU alu_out
//   alu_zero     <- ALU zero
//   res_valid    result present
//   res_ready    consumer accepts the result
//   res_data     result value
//   res_zero     1 iff the accumulator operand of this instruction was 0
//   acc_q        current accumulator value
//
// Optional build macro ALU_ACC_SEQ_CHECK_EN adds a golden-model checker:
//   chk_err      sticky, set on any ALU result mismatch
//   chk_cnt      saturating 8-bit mismatch count
// ---------------------------------------------------------------------------
module alu_acc_seq #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [OPW-1:0]   instr_op,
    input  logic [WIDTH-1:0] instr_data,
    input  logic             instr_load,
    input  logic             instr_wb,
    output logic [OPW-1:0]   alu_opcode,
    output logic [WIDTH-1:0] alu_data,
    output logic [WIDTH-1:0] alu_accum,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic [WIDTH-1:0] acc_q
`ifdef ALU_ACC_SEQ_CHECK_EN
    ,
    output logic             chk_err,
    output logic [7:0]       chk_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CAPT,
        RESP
    } state_t;

    state_t state_q;
    state_t state_d;

    logic ready_d;
    logic alu_accept;
    logic load_accept;
    logic capture;
    logic wb_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // instr_ready is registered, so its next value is decided here together
    // with the state: it stays low through EXEC/CAPT/RESP and comes back the
    // edge after the result handshake.
    always_comb begin
        state_d     = state_q;
        ready_d     = 1'b0;
        alu_accept  = 1'b0;
        load_accept = 1'b0;
        capture     = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_valid && instr_ready) begin
                    if (instr_load) begin
                        load_accept = 1'b1;
                        state_d     = RESP;
                    end else begin
                        alu_accept  = 1'b1;
                        state_d     = EXEC;
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            EXEC: begin
                state_d = CAPT;
            end
            CAPT: begin
                capture = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign res_valid = (state_q == RESP);

    // ALU inputs are loaded only on an accepted ALU instruction and otherwise
    // hold, so the ALU always sees stable, defined operands. The write-back
    // flag is latched alongside so later input changes cannot affect it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_ready <= 1'b0;
            alu_opcode  <= '0;
            alu_data    <= '0;
            alu_accum   <= '0;
            wb_q        <= 1'b0;
            acc_q       <= '0;
            res_data    <= '0;
            res_zero    <= 1'b0;
        end else begin
            instr_ready <= ready_d;
            if (alu_accept) begin
                alu_opcode <= instr_op;
                alu_data   <= instr_data;
                alu_accum  <= acc_q;
                wb_q       <= instr_wb;
            end
            if (load_accept) begin
                acc_q    <= instr_data;
                res_data <= instr_data;
                res_zero <= (acc_q == '0);
            end
            if (capture) begin
                res_data <= alu_result;
                res_zero <= alu_zero;
                if (wb_q) begin
                    acc_q <= alu_result;
                end
            end
        end
    end

`ifdef ALU_ACC_SEQ_CHECK_EN
    logic [WIDTH-1:0] golden;

    // Reference ALU function evaluated on the operands held in the alu_*
    // registers, which are still stable when the result is captured.
    always_comb begin
        golden = alu_accum;
        case (alu_opcode)
            OPW'(0): golden = alu_accum;
            OPW'(1): golden = alu_accum + alu_data;
            OPW'(2): golden = alu_accum - alu_data;
            OPW'(3): golden = alu_accum & alu_data;
            OPW'(4): golden = alu_accum ^ alu_data;
            OPW'(5): golden = ~alu_accum + WIDTH'(1);
            OPW'(6): golden = (alu_accum * WIDTH'(5)) + (alu_accum >> 3);
            OPW'(7): golden = (alu_accum >= WIDTH'(32)) ? alu_data : ~alu_data;
            default: golden = alu_accum;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chk_err <= 1'b0;
            chk_cnt <= 8'd0;
        end else if (capture && (alu_result != golden)) begin
            chk_err <= 1'b1;
            if (chk_cnt != 8'hFF) begin
                chk_cnt <= chk_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_acc_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_acc_seq
//
// Self-checking bench for alu_acc_seq. A behavioural registered ALU closes
// the loop around the sequencer. Directed vectors come from a table, then a
// few hand-written corner sequences (backpressure with upstream holding
// valid, reset mid-instruction, optional checker), then randomized
// instructions compared against a reference accumulator model.
// ---------------------------------------------------------------------------
module tb_alu_acc_seq;

    localparam int WIDTH = 8;
    localparam int OPW   = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             instr_valid;
    logic             instr_ready;
    logic [OPW-1:0]   instr_op;
    logic [WIDTH-1:0] instr_data;
    logic             instr_load;
    logic             instr_wb;
    logic [OPW-1:0]   alu_opcode;
    logic [WIDTH-1:0] alu_data;
    logic [WIDTH-1:0] alu_accum;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_zero;
    logic [WIDTH-1:0] acc_q;
`ifdef ALU_ACC_SEQ_CHECK_EN
    logic             chk_err;
    logic [7:0]       chk_cnt;
`endif

    int tests = 0;
    int fails = 0;
    logic [7:0] ref_acc = 8'h00;
    logic bad_alu = 1'b0;

    always #5 clk = ~clk;

    alu_acc_seq #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_data  (instr_data),
        .instr_load  (instr_load),
        .instr_wb    (instr_wb),
        .alu_opcode  (alu_opcode),
        .alu_data    (alu_data),
        .alu_accum   (alu_accum),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_zero    (res_zero),
        .acc_q       (acc_q)
`ifdef ALU_ACC_SEQ_CHECK_EN
        ,
        .chk_err     (chk_err),
        .chk_cnt     (chk_cnt)
`endif
    );

    // ALU behaviour in plain integer arithmetic, truncated to 8 bits.
    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] d, input logic [7:0] a);
        int ai;
        int di;
        int t;
        ai = int'(a);
        di = int'(d);
        case (op)
            3'd0: t = ai;
            3'd1: t = ai + di;
            3'd2: t = ai - di;
            3'd3: t = int'(a & d);
            3'd4: t = int'(a ^ d);
            3'd5: t = -ai;
            3'd6: t = ai * 5 + ai / 8;
            default: t = (ai >= 32) ? di : int'(~d);
        endcase
        return t[7:0];
    endfunction

    // Registered ALU model; bad_alu corrupts its output on purpose.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_result <= 8'h00;
            alu_zero   <= 1'b0;
        end else begin
            alu_result <= bad_alu ? 8'hFF : alu_fn(alu_opcode, alu_data, alu_accum);
            alu_zero   <= (alu_accum == 8'h00);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issues one instruction from a negedge, scrambles the instruction inputs
    // after acceptance, checks latency and result, holds res_ready low for
    // `stall` cycles (optionally with instr_valid held high), then completes
    // the handshake. Returns at a negedge.
    task automatic applyStimulus(input logic ld, input logic [2:0] op, input logic [7:0] data,
                                 input logic wb, input logic [7:0] exp_data, input logic exp_zero,
                                 input logic [7:0] exp_acc, input int stall, input bit hold_valid);
        int waited;
        int lat;
        waited = 0;
        while (instr_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (instr_ready !== 1'b1) begin
            checkOutput("ready_timeout", 32'(instr_ready), 32'd1);
        end
        instr_valid = 1'b1;
        instr_load  = ld;
        instr_op    = op;
        instr_data  = data;
        instr_wb    = wb;
        @(negedge clk);
        checkOutput("ready_after_accept", 32'(instr_ready), 32'd0);
        if (!ld) begin
            checkOutput("alu_opcode", 32'(alu_opcode), 32'(op));
            checkOutput("alu_data", 32'(alu_data), 32'(data));
            checkOutput("alu_accum", 32'(alu_accum), 32'(ref_acc));
        end
        instr_valid = 1'b0;
        instr_load  = 1'($urandom);
        instr_op    = 3'($urandom);
        instr_data  = 8'($urandom);
        instr_wb    = 1'($urandom);
        res_ready   = (stall == 0);
        lat = 0;
        while (res_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", 32'(lat), ld ? 32'd0 : 32'd2);
        checkOutput("res_data", 32'(res_data), 32'(exp_data));
        checkOutput("res_zero", 32'(res_zero), 32'(exp_zero));
        checkOutput("acc_q", 32'(acc_q), 32'(exp_acc));
        for (int i = 0; i < stall; i++) begin
            if (hold_valid) begin
                instr_valid = 1'b1;
                instr_load  = 1'($urandom);
                instr_op    = 3'($urandom);
                instr_data  = 8'($urandom);
            end
            @(negedge clk);
            checkOutput("stall_res_valid", 32'(res_valid), 32'd1);
            checkOutput("stall_res_data", 32'(res_data), 32'(exp_data));
            checkOutput("stall_instr_ready", 32'(instr_ready), 32'd0);
            checkOutput("stall_acc_q", 32'(acc_q), 32'(exp_acc));
        end
        res_ready = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_handshake", 32'(instr_ready), 32'd1);
        checkOutput("valid_after_handshake", 32'(res_valid), 32'd0);
        instr_valid = 1'b0;
        ref_acc = exp_acc;
    endtask

    typedef struct {
        logic       ld;
        logic [2:0] op;
        logic [7:0] data;
        logic       wb;
        logic [7:0] exp_data;
        logic       exp_zero;
        logic [7:0] exp_acc;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [7:0] e_data;
        logic [7:0] e_acc;
        logic       r_ld;
        logic [2:0] r_op;
        logic [7:0] r_data;
        logic       r_wb;

        vecs.push_back('{1'b1, 3'd0, 8'h05, 1'b0, 8'h05, 1'b1, 8'h05});
        vecs.push_back('{1'b0, 3'd1, 8'h03, 1'b1, 8'h08, 1'b0, 8'h08});
        vecs.push_back('{1'b0, 3'd6, 8'h77, 1'b0, 8'h29, 1'b0, 8'h08});
        vecs.push_back('{1'b0, 3'd0, 8'h11, 1'b0, 8'h08, 1'b0, 8'h08});
        vecs.push_back('{1'b0, 3'd2, 8'h0A, 1'b1, 8'hFE, 1'b0, 8'hFE});
        vecs.push_back('{1'b0, 3'd5, 8'h00, 1'b1, 8'h02, 1'b0, 8'h02});
        vecs.push_back('{1'b0, 3'd7, 8'h55, 1'b1, 8'hAA, 1'b0, 8'hAA});
        vecs.push_back('{1'b0, 3'd7, 8'h55, 1'b0, 8'h55, 1'b0, 8'hAA});
        vecs.push_back('{1'b0, 3'd3, 8'h0F, 1'b1, 8'h0A, 1'b0, 8'h0A});
        vecs.push_back('{1'b0, 3'd4, 8'h0A, 1'b1, 8'h00, 1'b0, 8'h00});
        vecs.push_back('{1'b0, 3'd1, 8'h07, 1'b0, 8'h07, 1'b1, 8'h00});
        vecs.push_back('{1'b1, 3'd5, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00});
        vecs.push_back('{1'b1, 3'd0, 8'h80, 1'b0, 8'h80, 1'b1, 8'h80});
        vecs.push_back('{1'b1, 3'd0, 8'h33, 1'b1, 8'h33, 1'b0, 8'h33});

        reset_n     = 1'b0;
        instr_valid = 1'b0;
        instr_op    = 3'd0;
        instr_data  = 8'h00;
        instr_load  = 1'b0;
        instr_wb    = 1'b0;
        res_ready   = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_instr_ready", 32'(instr_ready), 32'd0);
        checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("rst_res_data", 32'(res_data), 32'd0);
        checkOutput("rst_acc_q", 32'(acc_q), 32'd0);
        checkOutput("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        reset_n = 1'b1;
        #1;
        checkOutput("release_instr_ready", 32'(instr_ready), 32'd0);
        @(negedge clk);
        checkOutput("first_edge_instr_ready", 32'(instr_ready), 32'd1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ld, vecs[i].op, vecs[i].data, vecs[i].wb,
                          vecs[i].exp_data, vecs[i].exp_zero, vecs[i].exp_acc, 0, 1'b0);
        end

        // Backpressure for 5 cycles with a second instruction waiting upstream.
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 8'h33, 1'b0, 8'h33, 5, 1'b1);

        // Reset while the ALU instruction sits in EXEC.
        instr_valid = 1'b1;
        instr_load  = 1'b0;
        instr_op    = 3'd1;
        instr_data  = 8'h01;
        instr_wb    = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        reset_n     = 1'b0;
        #1;
        checkOutput("midrst_instr_ready", 32'(instr_ready), 32'd0);
        checkOutput("midrst_res_valid", 32'(res_valid), 32'd0);
        checkOutput("midrst_res_data", 32'(res_data), 32'd0);
        checkOutput("midrst_res_zero", 32'(res_zero), 32'd0);
        checkOutput("midrst_acc_q", 32'(acc_q), 32'd0);
        checkOutput("midrst_alu_opcode", 32'(alu_opcode), 32'd0);
        checkOutput("midrst_alu_data", 32'(alu_data), 32'd0);
        checkOutput("midrst_alu_accum", 32'(alu_accum), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("midrst_hold_res_valid", 32'(res_valid), 32'd0);
        reset_n = 1'b1;
        ref_acc = 8'h00;
        @(negedge clk);
        checkOutput("midrst_release_ready", 32'(instr_ready), 32'd1);
        checkOutput("midrst_no_result", 32'(res_valid), 32'd0);
        applyStimulus(1'b0, 3'd0, 8'h5A, 1'b0, 8'h00, 1'b1, 8'h00, 0, 1'b0);

`ifdef ALU_ACC_SEQ_CHECK_EN
        checkOutput("chk_err_clean", 32'(chk_err), 32'd0);
        checkOutput("chk_cnt_clean", 32'(chk_cnt), 32'd0);
        applyStimulus(1'b1, 3'd0, 8'h08, 1'b0, 8'h08, 1'b1, 8'h08, 0, 1'b0);
        bad_alu = 1'b1;
        applyStimulus(1'b0, 3'd1, 8'h03, 1'b0, 8'hFF, 1'b0, 8'h08, 0, 1'b0);
        bad_alu = 1'b0;
        checkOutput("chk_err_set", 32'(chk_err), 32'd1);
        checkOutput("chk_cnt_one", 32'(chk_cnt), 32'd1);
        applyStimulus(1'b0, 3'd1, 8'h03, 1'b0, 8'h0B, 1'b0, 8'h08, 0, 1'b0);
        applyStimulus(1'b0, 3'd4, 8'hF0, 1'b1, 8'hF8, 1'b0, 8'hF8, 0, 1'b0);
        checkOutput("chk_err_sticky", 32'(chk_err), 32'd1);
        checkOutput("chk_cnt_sticky", 32'(chk_cnt), 32'd1);
`endif

        // Randomized instructions against the reference accumulator model.
        for (int n = 0; n < 150; n++) begin
            r_ld   = ($urandom_range(0, 3) == 0);
            r_op   = 3'($urandom);
            r_data = 8'($urandom);
            r_wb   = 1'($urandom);
            if (r_ld) begin
                e_data = r_data;
                e_acc  = r_data;
            end else begin
                e_data = alu_fn(r_op, r_data, ref_acc);
                e_acc  = r_wb ? e_data : ref_acc;
            end
            applyStimulus(r_ld, r_op, r_data, r_wb, e_data, (ref_acc == 8'h00), e_acc,
                          int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
